// File: rtl/mem_responder.sv
// mem_responder: single-port word memory shared by the fetch and load/store ports.
// One access per cycle, 1-cycle read latency, load/store priority with fetch anti-starvation.
//
// Ports:
//   clk, reset        clock, async active-low reset
//   pc_req_valid/pc_addr          -> pc_req_ready  fetch request / accept
//   pc_rdata/pc_rvalid            fetch response (registered)
//   ls_req_valid/ls_write/ls_addr/ls_wdata -> ls_req_ready  load/store request / accept
//   ls_rdata/ls_rvalid            load data or echoed store data (registered)
//   stall_count                   saturating count of cycles with a refused request
module mem_responder #(
  parameter int WIDTH        = 16,
  parameter int ADDR_BITS    = 10,
  parameter int STARVE_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_req_valid,
  input  logic [WIDTH-1:0] pc_addr,
  output logic             pc_req_ready,
  output logic [WIDTH-1:0] pc_rdata,
  output logic             pc_rvalid,
  input  logic             ls_req_valid,
  input  logic             ls_write,
  input  logic [WIDTH-1:0] ls_addr,
  input  logic [WIDTH-1:0] ls_wdata,
  output logic             ls_req_ready,
  output logic [WIDTH-1:0] ls_rdata,
  output logic             ls_rvalid,
  output logic [WIDTH-1:0] stall_count
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int SW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [WIDTH-1:0] mem [DEPTH];

  logic                 both_req;
  logic                 gnt_pc;
  logic                 gnt_ls;
  logic                 refused;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] idx;
  logic [WIDTH-1:0]     rd_word;
  logic                 unused_addr;

  logic             pc_rvalid_q, pc_rvalid_d;
  logic [WIDTH-1:0] pc_rdata_q, pc_rdata_d;
  logic             ls_rvalid_q, ls_rvalid_d;
  logic [WIDTH-1:0] ls_rdata_q, ls_rdata_d;
  logic [WIDTH-1:0] stall_q, stall_d;
  logic [SW-1:0]    starve_q, starve_d;

  // Upper address bits alias; only the low index is used.
  assign unused_addr = ^{pc_addr, ls_addr};

  always_comb begin
    both_req = pc_req_valid && ls_req_valid;
    gnt_pc   = 1'b0;
    gnt_ls   = 1'b0;
    unique case (1'b1)
      both_req: begin
        if (starve_q == STARVE_MAX) gnt_pc = 1'b1;
        else                        gnt_ls = 1'b1;
      end
      pc_req_valid && !ls_req_valid: gnt_pc = 1'b1;
      ls_req_valid && !pc_req_valid: gnt_ls = 1'b1;
      default: ;
    endcase
  end

  assign pc_req_ready = gnt_pc;
  assign ls_req_ready = gnt_ls;

  always_comb begin
    idx     = gnt_ls ? ls_addr[ADDR_BITS-1:0]
                     : pc_addr[ADDR_BITS-1:0];
    rd_word = mem[idx];
    mem_we  = gnt_ls && ls_write;
  end

  always_comb begin
    pc_rvalid_d = gnt_pc;
    pc_rdata_d  = gnt_pc ? rd_word : pc_rdata_q;
    ls_rvalid_d = gnt_ls;
    ls_rdata_d  = ls_rdata_q;
    if (gnt_ls) begin
      ls_rdata_d = ls_write ? ls_wdata : rd_word;
    end
  end

  // At most one port is refused per cycle, so one increment suffices.
  always_comb begin
    refused = (pc_req_valid && !gnt_pc) ||
              (ls_req_valid && !gnt_ls);
    stall_d = stall_q;
    if (refused && !(&stall_q)) begin
      stall_d = stall_q + WIDTH'(1);
    end
  end

  // Counts consecutive cycles where fetch lost to load/store.
  always_comb begin
    starve_d = '0;
    if (both_req && gnt_ls) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q
                                          : starve_q + SW'(1);
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= ls_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_rvalid_q <= 1'b0;
      pc_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      stall_q     <= '0;
      starve_q    <= '0;
    end else begin
      pc_rvalid_q <= pc_rvalid_d;
      pc_rdata_q  <= pc_rdata_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
      stall_q     <= stall_d;
      starve_q    <= starve_d;
    end
  end

  assign pc_rvalid   = pc_rvalid_q;
  assign pc_rdata    = pc_rdata_q;
  assign ls_rvalid   = ls_rvalid_q;
  assign ls_rdata    = ls_rdata_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder.
// Responses are checked against a scoreboard queue fed at request time.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_req_valid;
  logic [15:0] pc_addr;
  logic        pc_req_ready;
  logic [15:0] pc_rdata;
  logic        pc_rvalid;
  logic        ls_req_valid;
  logic        ls_write;
  logic [15:0] ls_addr;
  logic [15:0] ls_wdata;
  logic        ls_req_ready;
  logic [15:0] ls_rdata;
  logic        ls_rvalid;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

  logic [15:0] pc_q [$];
  logic [15:0] ls_q [$];
  logic [15:0] ref_mem [1024];

  mem_responder #(
    .WIDTH(16), .ADDR_BITS(10), .STARVE_LIMIT(3)
  ) dut (
    .clk(clk), .reset(reset),
    .pc_req_valid(pc_req_valid), .pc_addr(pc_addr),
    .pc_req_ready(pc_req_ready), .pc_rdata(pc_rdata),
    .pc_rvalid(pc_rvalid),
    .ls_req_valid(ls_req_valid), .ls_write(ls_write),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_req_ready(ls_req_ready), .ls_rdata(ls_rdata),
    .ls_rvalid(ls_rvalid), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pc_rvalid) begin
      if (pc_q.size() == 0) chk("pc_rvalid_unexpected", 16'(pc_rvalid), 16'h0);
      else chk("pc_rdata", pc_rdata, pc_q.pop_front());
    end
    if (ls_rvalid) begin
      if (ls_q.size() == 0) chk("ls_rvalid_unexpected", 16'(ls_rvalid), 16'h0);
      else chk("ls_rdata", ls_rdata, ls_q.pop_front());
    end
  end

  // One cycle: drive, check grants, record expectations, advance.
  task automatic step(input bit pv, input logic [15:0] pa,
                      input bit lv, input bit lw,
                      input logic [15:0] la, input logic [15:0] ld,
                      input bit exp_pg, input bit exp_lg);
    pc_req_valid = pv;
    pc_addr      = pa;
    ls_req_valid = lv;
    ls_write     = lw;
    ls_addr      = la;
    ls_wdata     = ld;
    #1;
    chk("pc_req_ready", 16'(pc_req_ready), 16'(exp_pg));
    chk("ls_req_ready", 16'(ls_req_ready), 16'(exp_lg));
    if ((pv && !exp_pg) || (lv && !exp_lg)) exp_stall++;
    if (exp_lg) begin
      if (lw) begin
        ref_mem[la[9:0]] = ld;
        ls_q.push_back(ld);
      end else begin
        ls_q.push_back(ref_mem[la[9:0]]);
      end
    end
    if (exp_pg) pc_q.push_back(ref_mem[pa[9:0]]);
    @(negedge clk);
    #2;
    chk("stall_count", stall_count, 16'(exp_stall));
    chk("pc_latency", 16'(pc_q.size()), 16'h0);
    chk("ls_latency", 16'(ls_q.size()), 16'h0);
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    reset        = 1'b0;
    pc_req_valid = 1'b0;
    pc_addr      = '0;
    ls_req_valid = 1'b0;
    ls_write     = 1'b0;
    ls_addr      = '0;
    ls_wdata     = '0;
    foreach (ref_mem[i]) ref_mem[i] = 16'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk("rst_pc_rvalid", 16'(pc_rvalid), 16'h0);
    chk("rst_ls_rvalid", 16'(ls_rvalid), 16'h0);
    chk("rst_pc_rdata", pc_rdata, 16'h0);
    chk("rst_ls_rdata", ls_rdata, 16'h0);
    chk("rst_stall", stall_count, 16'h0);
    idle(); idle(); idle();

    // Store then fetch the same word.
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0005, 16'hBEEF, 1'b0, 1'b1);
    step(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle();
    chk("ls_rdata_hold", ls_rdata, 16'hBEEF);
    chk("pc_rdata_hold", pc_rdata, 16'hBEEF);

    // Simultaneous load and fetch.
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0006, 16'h1234, 1'b0, 1'b1);
    step(1'b1, 16'h0006, 1'b1, 1'b0, 16'h0005, 16'h0, 1'b0, 1'b1);
    chk("t3_ls_rdata", ls_rdata, 16'hBEEF);
    step(1'b1, 16'h0006, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("t3_pc_rdata", pc_rdata, 16'h1234);
    chk("t3_stall", stall_count, 16'd1);

    // Continuous contention: ls ls ls pc, twice.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'h0006, 1'b1, 1'b0, 16'h0005, 16'h0,
           (i % 4) == 3, (i % 4) != 3);
    end
    chk("t4_stall", stall_count, 16'd9);

    // Address aliasing modulo 1024.
    step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0405, 16'hA5A5, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0005, 16'h0, 1'b0, 1'b1);
    chk("t5_alias", ls_rdata, 16'hA5A5);
    idle();

    // Reset right after an accepted fetch drops the response.
    pc_req_valid = 1'b1;
    pc_addr      = 16'h0005;
    #1;
    chk("t6_pc_ready", 16'(pc_req_ready), 16'h1);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    pc_req_valid = 1'b0;
    exp_stall    = 0;
    @(negedge clk);
    chk("t6_pc_rvalid_rst", 16'(pc_rvalid), 16'h0);
    chk("t6_stall_rst", stall_count, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk("t6_pc_rvalid_rel", 16'(pc_rvalid), 16'h0);
    chk("t6_stall_rel", stall_count, 16'h0);
    step(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("t6_pc_rdata", pc_rdata, 16'hA5A5);
    idle(); idle();
    chk("end_pc_q", 16'(pc_q.size()), 16'h0);
    chk("end_ls_q", 16'(ls_q.size()), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
